// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use detection, branch flush gating,
// data-memory wait tracking with a watchdog, and stall/flush event counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       if_id_rs1_i,
  input  logic [4:0]       if_id_rs2_i,
  input  logic [4:0]       id_ex_rd_i,
  input  logic             id_ex_memread_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             mem_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [15:0]      wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             lu, ms, flush;

  always_comb begin
    lu = id_ex_memread_i && (id_ex_rd_i != 5'd0) &&
         ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));
  end

  // A request acked in the same cycle it appears never leaves IDLE.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    ms            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_req_i && !mem_ack_i) begin
          ms            = 1'b1;
          wait_cnt_next = 16'd1;
          state_next    = (TIMEOUT_L == 16'd1) ? ST_ERR : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_next    = ST_IDLE;
          wait_cnt_next = 16'd0;
        end else begin
          ms            = 1'b1;
          wait_cnt_next = wait_cnt_reg + 16'd1;
          if (wait_cnt_reg + 16'd1 == TIMEOUT_L) state_next = ST_ERR;
        end
      end
      ST_ERR:  ms = 1'b1;
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory stall outranks load-use, which outranks the branch flush.
  always_comb begin
    flush          = branch_taken_i && !ms && !lu;
    pc_write_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    mem_stall_o    = 1'b0;
    if (!rst_i) begin
      pc_write_o     = !ms && !lu;
      if_id_stall_o  = lu;
      if_id_flush_o  = flush;
      id_ex_bubble_o = lu && !ms;
      mem_stall_o    = ms;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= 16'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (ms || lu) stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (flush)    flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign err_o       = (state_reg == ST_ERR);
  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model (TIMEOUT=4, 4-bit counters).
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [4:0]    if_id_rs1_i, if_id_rs2_i, id_ex_rd_i;
  logic          id_ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
  logic          pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o;
  logic          mem_stall_o, err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_id_rs1_i(if_id_rs1_i), .if_id_rs2_i(if_id_rs2_i),
    .id_ex_rd_i(id_ex_rd_i), .id_ex_memread_i(id_ex_memread_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .if_id_stall_o(if_id_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
    .mem_stall_o(mem_stall_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Output vector order: {pc_write, if_id_stall, if_id_flush, id_ex_bubble, mem_stall}
  function automatic logic [4:0] outs();
    return {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, mem_stall_o};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic req, input logic ack);
    if_id_rs1_i = rs1; if_id_rs2_i = rs2; id_ex_rd_i = rd;
    id_ex_memread_i = mr; branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", outs(), 5'b00000);
    end
    n_checks++;
    if ({err_o, stall_cnt_o, flush_cnt_o} !== {1'b0, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL reset_state: got err=%b sc=%0d fc=%0d want 0 0 0", err_o, stall_cnt_o, flush_cnt_o);
    end
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b01010) begin
      n_fail++; $display("FAIL lu_hit: got %b want %b", outs(), 5'b01010);
    end
    step();
    drive(5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if ({outs(), stall_cnt_o} !== {5'b10000, 4'd1}) begin
      n_fail++; $display("FAIL lu_after: got %b cnt=%0d want 10000 cnt=1", outs(), stall_cnt_o);
    end
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b10000) begin
      n_fail++; $display("FAIL lu_rd0: got %b want %b", outs(), 5'b10000);
    end
    step();
    @(negedge clk_i);
    n_checks++;
    if (stall_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL lu_rd0_cnt: got %0d want 1", stall_cnt_o);
    end
    $display("test_load_use done");
  endtask

  task automatic test_mem_stall();
    do_reset();
    drive(0, 0, 0, 0, 0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (outs() !== 5'b00001) begin
        n_fail++; $display("FAIL mem_stall_c%0d: got %b want %b", i, outs(), 5'b00001);
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 1'b1, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b10000) begin
      n_fail++; $display("FAIL mem_ack_cycle: got %b want %b", outs(), 5'b10000);
    end
    step();
    drive(0, 0, 0, 0, 0, 1'b1, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if ({outs(), stall_cnt_o} !== {5'b10000, 4'd3}) begin
      n_fail++; $display("FAIL mem_same_cycle: got %b cnt=%0d want 10000 cnt=3", outs(), stall_cnt_o);
    end
    step();
    drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if ({mem_stall_o, stall_cnt_o} !== {1'b0, 4'd3}) begin
      n_fail++; $display("FAIL mem_idle: got ms=%b cnt=%0d want 0 3", mem_stall_o, stall_cnt_o);
    end
    $display("test_mem_stall done");
  endtask

  task automatic test_branch_during_stall();
    do_reset();
    drive(0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (outs() !== 5'b00001) begin
        n_fail++; $display("FAIL br_stall_c%0d: got %b want %b", i, outs(), 5'b00001);
      end
      step();
    end
    drive(0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b10100) begin
      n_fail++; $display("FAIL br_release: got %b want %b", outs(), 5'b10100);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++;
    if ({flush_cnt_o, stall_cnt_o} !== {4'd1, 4'd2}) begin
      n_fail++; $display("FAIL br_counts: got fc=%0d sc=%0d want 1 2", flush_cnt_o, stall_cnt_o);
    end
    $display("test_branch_during_stall done");
  endtask

  task automatic test_lu_branch();
    do_reset();
    drive(5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b01010) begin
      n_fail++; $display("FAIL lubr_hold: got %b want %b", outs(), 5'b01010);
    end
    step();
    drive(5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b10100) begin
      n_fail++; $display("FAIL lubr_flush: got %b want %b", outs(), 5'b10100);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++;
    if ({flush_cnt_o, stall_cnt_o} !== {4'd1, 4'd1}) begin
      n_fail++; $display("FAIL lubr_counts: got fc=%0d sc=%0d want 1 1", flush_cnt_o, stall_cnt_o);
    end
    $display("test_lu_branch done");
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 0, 0, 0, 0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({mem_stall_o, err_o} !== {1'b1, (i > TO) ? 1'b1 : 1'b0}) begin
        n_fail++; $display("FAIL timeout_c%0d: got ms=%b err=%b want ms=1 err=%b", i, mem_stall_o, err_o, i > TO);
      end
      step();
    end
    @(negedge clk_i);
    n_checks++;
    if (stall_cnt_o !== 4'd8) begin
      n_fail++; $display("FAIL timeout_cnt: got %0d want 8", stall_cnt_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (outs() !== 5'b00000) begin
      n_fail++; $display("FAIL timeout_rst_force: got %b want %b", outs(), 5'b00000);
    end
    step();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 1'b1, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if ({err_o, stall_cnt_o, flush_cnt_o, mem_stall_o} !== {1'b0, 4'd0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL timeout_recover: got err=%b sc=%0d fc=%0d ms=%b want 0 0 0 0", err_o, stall_cnt_o, flush_cnt_o, mem_stall_o);
    end
    $display("test_timeout done");
  endtask

  task automatic test_wrap();
    do_reset();
    drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) begin
        @(negedge clk_i);
        n_checks++;
        if (stall_cnt_o !== 4'd15) begin
          n_fail++; $display("FAIL wrap_15: got %0d want 15", stall_cnt_o);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++;
    if (stall_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL wrap_0: got %0d want 0", stall_cnt_o);
    end
    $display("test_wrap done");
  endtask

  // Reference model: consecutive unacked-request cycles, sticky error, event counts.
  task automatic test_random();
    int  run = 0, sc = 0, fc = 0;
    bit  err = 0;
    bit  r, mr, br, req, ack, lu, ms, fl;
    logic [4:0] rs1, rs2, rd, exp_o;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      r   = ($urandom_range(0, 39) == 0);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      mr  = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      req = (run > 0 && !err) ? 1'b1 : 1'($urandom_range(0, 1));
      ack = ($urandom_range(0, 2) == 0);
      rst_i = r;
      drive(rs1, rs2, rd, mr, br, req, ack);
      lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
      ms = err || (req && !ack);
      fl = br && !ms && !lu;
      exp_o = r ? 5'b00000 : {!ms && !lu, lu, fl, lu && !ms, ms};
      @(negedge clk_i);
      n_checks++;
      if ({outs(), err_o, stall_cnt_o, flush_cnt_o} !== {exp_o, err, 4'(sc), 4'(fc)}) begin
        n_fail++;
        $display("FAIL rand_c%0d: got o=%b err=%b sc=%0d fc=%0d want o=%b err=%b sc=%0d fc=%0d",
                 c, outs(), err_o, stall_cnt_o, flush_cnt_o, exp_o, err, sc, fc);
      end
      $display("rand %0d: rst=%b req=%b ack=%b lu=%b br=%b o=%b", c, r, req, ack, lu, br, outs());
      step();
      if (r) begin
        run = 0; err = 0; sc = 0; fc = 0;
      end else begin
        if (ms || lu) sc = (sc + 1) % 16;
        if (fl)       fc = (fc + 1) % 16;
        if (!err) begin
          if (req && !ack) begin
            run++;
            if (run >= TO) err = 1;
          end else begin
            run = 0;
          end
        end
      end
    end
    rst_i = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_mem_stall();
    test_branch_during_stall();
    test_lu_branch();
    test_timeout();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It decides every cycle whether the PC advances, whether IF/ID holds or flushes, and whether a bubble enters ID/EX. It also tracks outstanding data-memory accesses in a small FSM with a watchdog timeout. Its outputs drive the PC write-enable, the IF/ID `stall_i`/`flush_i`/`MemStall_i` inputs and the ID/EX bubble control, and it keeps stall/flush performance counters.

## Interface
- `TIMEOUT`, default 255: consecutive memory-stall cycles allowed before entering ERR; legal range 1..2^16-1.
- `CNT_W`, default 32: width of the performance counters.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `if_id_rs1_i`  in  5  rs1 field of the instruction in ID.
- `if_id_rs2_i`  in  5  rs2 field of the instruction in ID.
- `id_ex_rd_i`  in  5  rd of the instruction in EX.
- `id_ex_memread_i`  in  1  the instruction in EX is a load.
- `branch_taken_i`  in  1  a branch or jump resolved taken in ID this cycle.
- `mem_req_i`  in  1  MEM stage requests data memory; held high until `mem_ack_i`.
- `mem_ack_i`  in  1  data memory completes the access this cycle.
- `pc_write_o`  out  1  PC register write enable.
- `if_id_stall_o`  out  1  IF/ID hold because of a load-use hazard.
- `if_id_flush_o`  out  1  IF/ID flush.
- `id_ex_bubble_o`  out  1  ID/EX loads a NOP.
- `mem_stall_o`  out  1  global freeze of all pipeline registers.
- `err_o`  out  1  sticky memory-timeout flag.
- `stall_cnt_o`  out  CNT_W  count of cycles with `mem_stall_o` or load-use asserted.
- `flush_cnt_o`  out  CNT_W  count of cycles with `if_id_flush_o` asserted.

## Operation
- Load-use signal `lu = id_ex_memread_i & (id_ex_rd_i != 0) & (id_ex_rd_i == if_id_rs1_i | id_ex_rd_i == if_id_rs2_i)`.
- Memory FSM states are IDLE, WAIT and ERR. `wait_cnt` is 16 bits.
  - IDLE: if `mem_req_i & ~mem_ack_i`, go to WAIT with `wait_cnt=1`. If TIMEOUT==1, go to ERR instead. Otherwise stay in IDLE; a request acked in the same cycle costs zero stalls.
  - WAIT: if `mem_ack_i`, go to IDLE and clear `wait_cnt`. Otherwise `wait_cnt+1`; when that value equals TIMEOUT, go to ERR.
  - ERR: stays in ERR until `rst_i`. `err_o=1`.
- `ms` = (IDLE & `mem_req_i` & ~`mem_ack_i`) | (WAIT & ~`mem_ack_i`) | ERR. `mem_ack_i` with `mem_req_i=0` in IDLE is ignored.
- Combinational outputs (same-cycle, consumed at the next edge):
  - `mem_stall_o = ms`
  - `pc_write_o = ~ms & ~lu`
  - `if_id_stall_o = lu`
  - `id_ex_bubble_o = lu & ~ms`
  - `if_id_flush_o = branch_taken_i & ~ms & ~lu`
- Priority is memory stall, then load-use, then branch flush.
  - During a memory stall the branch stays held in ID, so `branch_taken_i` persists and the flush fires on the first non-stalled cycle. Flushing earlier would destroy the branch while the PC is frozen.
  - On load-use combined with a branch, the branch was resolved with a stale operand. The controller stalls, does not flush and does not write the PC; the branch is re-evaluated next cycle.
- Counters:
  - `stall_cnt_o` increments on every cycle where `ms | lu`.
  - `flush_cnt_o` increments on every cycle where `if_id_flush_o`.
  - Both wrap modulo 2^CNT_W.
  - Both keep counting in ERR; `stall_cnt_o` increments every ERR cycle.

## Timing
- Reset (`rst_i=1` at an edge): state IDLE, `wait_cnt=0`, `err_o=0`, both counters 0.
- While `rst_i` is high, combinational outputs are forced to `pc_write_o=0`, `if_id_stall_o=0`, `if_id_flush_o=0`, `id_ex_bubble_o=0`, `mem_stall_o=0`.
- Reset mid-WAIT or in ERR returns to IDLE at that edge. No pending state survives.
- Load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM, the hazard clears and the bubble sits in EX.
- Memory stall length equals the cycles from the first `mem_req_i` without ack through the ack cycle exclusive. `mem_stall_o` drops in the ack cycle itself.
- ERR is entered at the edge ending the TIMEOUT-th consecutive stalled cycle. `err_o` reads 1 from the next cycle on.
- Counters are registered and reflect events up to the previous edge (1-cycle latency).

## Test plan
- Load `rd=5` in EX, `rs2=5` in ID: 1 cycle with `pc_write_o=0`, `if_id_stall_o=1`, `id_ex_bubble_o=1`, then all inactive; `stall_cnt_o` becomes 1. Repeat with `rd=0`: no stall.
- `mem_req_i` held, ack in the 4th cycle: `mem_stall_o=1` for 3 cycles and 0 in the ack cycle; `stall_cnt_o=3`; state back in IDLE. `mem_req_i` and `mem_ack_i` in the same cycle: no stall.
- `branch_taken_i` held during a 2-cycle memory stall: `if_id_flush_o=0` for those 2 cycles, then 1 with `pc_write_o=1` in the next cycle; `flush_cnt_o=1`.
- Load-use plus `branch_taken_i` in the same cycle: `if_id_flush_o=0`, `pc_write_o=0`, `if_id_stall_o=1`. Next cycle, with the hazard gone, `if_id_flush_o=1`.
- TIMEOUT=4, `mem_req_i` held and never acked: `mem_stall_o=1` for cycles 1-4, `err_o=1` from cycle 5 and staying 1. Asserting `rst_i` for one edge gives `err_o=0`, counters 0 and IDLE.
- `stall_cnt_o` preloaded near wrap via CNT_W=4 build: 16 stall cycles return the count to 0.
